// File: rtl/mips_isa_pkg.sv
// MIPS opcode/func encodings shared with the control unit, loader state encoding
// and the set of instruction words the single-cycle CPU supports.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_EXT1  = 6'b000001;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_WRITE, ST_CSUM, ST_DONE, ST_ERR
  } ld_state_t;

  function automatic logic legal_func(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_EXT1, FN_SRL, FN_SRA, FN_JR,
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: legal_func = 1'b1;
      default:                               legal_func = 1'b0;
    endcase
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    case (op)
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: legal_op = 1'b1;
      default:                               legal_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    is_legal = (op == OP_RTYPE) ? legal_func(fn) : legal_op(op);
  endfunction

endpackage

// File: rtl/instr_legal_chk.sv
// Combinational check that a 32-bit word is in the supported MIPS subset.
module instr_legal_chk
  import mips_isa_pkg::*;
(
  input  logic [31:0] word,
  output logic        legal
);

  // register/immediate fields do not affect legality
  logic unused_fields;
  assign unused_fields = ^word[25:6];

  assign legal = is_legal(word[31:26], word[5:0]);

endmodule

// File: rtl/sc_imem_loader.sv
// Byte-stream instruction-memory loader: assembles big-endian words, flags
// unsupported instructions, verifies a trailing XOR checksum, then releases the CPU.
module sc_imem_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  output logic              err,
  output logic              err_illegal,
  output logic [ADDR_W-1:0] illegal_addr
);

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  ld_state_t         state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic [7:0]        csum;
  logic [1:0]        idx;
  logic [7:0]        len;
  logic [7:0]        wcnt;
  logic              legal;

  instr_legal_chk u_chk (
    .word  (word),
    .legal (legal)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      addr         <= '0;
      word         <= '0;
      csum         <= '0;
      idx          <= '0;
      len          <= '0;
      wcnt         <= '0;
      err_illegal  <= 1'b0;
      illegal_addr <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            addr         <= '0;
            csum         <= '0;
            idx          <= '0;
            wcnt         <= '0;
            err_illegal  <= 1'b0;
            illegal_addr <= '0;
            state        <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (byte_valid) begin
            if (byte_data == 8'd0 || {9'd0, byte_data} > CAP) begin
              state <= ST_ERR;
            end else begin
              len   <= byte_data;
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            word <= {word[23:0], byte_data};
            csum <= csum ^ byte_data;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // only the first unsupported word's address is kept
          if (!legal && !err_illegal) begin
            err_illegal  <= 1'b1;
            illegal_addr <= addr;
          end
          addr <= addr + ADDR_W'(1);
          wcnt <= wcnt + 8'd1;
          state <= (wcnt + 8'd1 == len) ? ST_CSUM : ST_DATA;
        end
        ST_CSUM: begin
          if (byte_valid) state <= (byte_data == csum) ? ST_DONE : ST_ERR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign busy       = byte_ready || (state == ST_WRITE);
  assign im_we      = (state == ST_WRITE);
  assign im_addr    = addr;
  assign im_wdata   = word;
  assign done       = (state == ST_DONE);
  assign cpu_run    = done;
  assign err        = (state == ST_ERR);

endmodule

// File: tb/tb_sc_imem_loader.sv
// Directed bench for sc_imem_loader: clean loads, illegal words, checksum and
// length errors, stalled stream and mid-load reset.
module tb_sc_imem_loader;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, im_we, busy, done, cpu_run, err, err_illegal;
  logic [5:0]  im_addr, illegal_addr;
  logic [31:0] im_wdata;

  int total = 0;
  int bad = 0;

  int          wr_n = 0;
  logic [5:0]  wr_addr [0:127];
  logic [31:0] wr_data [0:127];
  logic [31:0] words [0:63];
  int          gap_max = 0;

  sc_imem_loader #(.ADDR_W(6)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .cpu_run(cpu_run), .err(err),
    .err_illegal(err_illegal), .illegal_addr(illegal_addr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (im_we && wr_n < 128) begin
      wr_addr[wr_n] = im_addr;
      wr_data[wr_n] = im_wdata;
      wr_n = wr_n + 1;
    end
  end

  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent = 0;
    int g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (g) @(posedge clock);
    #1;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !sent; i++) begin
      @(negedge clock);
      if (byte_ready) sent = 1;
      @(posedge clock); #1;
    end
    byte_valid = 1'b0;
    total++;
    if (!sent) begin
      bad++;
      $display("FAIL byte_accept: byte %02h never accepted (byte_ready stayed 0)", b);
    end
  endtask

  // sends N, words[0..n-1] MSB first, then (XOR of data bytes) ^ csum_flip
  task automatic send_load(input int n, input logic [7:0] n_byte, input logic [7:0] csum_flip);
    logic [7:0] cs = 8'h00;
    send_byte(n_byte);
    for (int w = 0; w < n; w++) begin
      for (int k = 3; k >= 0; k--) begin
        send_byte(words[w][k*8 +: 8]);
        cs = cs ^ words[w][k*8 +: 8];
      end
    end
    send_byte(cs ^ csum_flip);
  endtask

  task automatic wait_end(input string name);
    bit ended = 0;
    for (int i = 0; i < 20 && !ended; i++) begin
      if (done || err) ended = 1;
      else begin @(posedge clock); #1; end
    end
    total++;
    if (!ended) begin
      bad++;
      $display("FAIL %s_timeout: done=%0b err=%0b, required done or err", name, done, err);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({byte_ready, im_we, im_addr, im_wdata, busy, done, cpu_run, err, err_illegal, illegal_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%0b we=%0b addr=%0d wd=%h busy=%0b done=%0b run=%0b err=%0b ill=%0b iaddr=%0d, required all 0",
               byte_ready, im_we, im_addr, im_wdata, busy, done, cpu_run, err, err_illegal, illegal_addr);
    end
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_clean_load();
    wr_n = 0;
    words[0] = 32'h20080005;
    words[1] = 32'h01094020;
    pulse_start();
    total++;
    if (!(busy && byte_ready)) begin
      bad++;
      $display("FAIL clean_busy: busy=%0b byte_ready=%0b, required 1 1", busy, byte_ready);
    end
    send_load(2, 8'd2, 8'h00);
    wait_end("clean");
    total++;
    if (wr_n !== 2 || wr_addr[0] !== 6'd0 || wr_data[0] !== 32'h20080005 ||
        wr_addr[1] !== 6'd1 || wr_data[1] !== 32'h01094020) begin
      bad++;
      $display("FAIL clean_writes: n=%0d a0=%0d d0=%h a1=%0d d1=%h, required 2 0 20080005 1 01094020",
               wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    total++;
    if ({done, cpu_run, err, err_illegal, busy} !== 5'b11000) begin
      bad++;
      $display("FAIL clean_status: done=%0b run=%0b err=%0b ill=%0b busy=%0b, required 1 1 0 0 0",
               done, cpu_run, err, err_illegal, busy);
    end
  endtask

  task automatic test_illegal();
    wr_n = 0;
    words[0] = 32'hFC000000;
    pulse_start();
    send_load(1, 8'd1, 8'h00);
    wait_end("illegal");
    total++;
    if (wr_n !== 1 || wr_addr[0] !== 6'd0 || wr_data[0] !== 32'hFC000000) begin
      bad++;
      $display("FAIL illegal_write: n=%0d a0=%0d d0=%h, required 1 0 fc000000", wr_n, wr_addr[0], wr_data[0]);
    end
    total++;
    if ({err_illegal, illegal_addr, done, cpu_run} !== {1'b1, 6'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL illegal_flags: ill=%0b iaddr=%0d done=%0b run=%0b, required 1 0 1 1",
               err_illegal, illegal_addr, done, cpu_run);
    end
    // legal, illegal (SLT func 101010), illegal: first illegal address kept
    wr_n = 0;
    words[0] = 32'h3C010001;
    words[1] = 32'h0022182A;
    words[2] = 32'hFC000000;
    pulse_start();
    total++;
    if (err_illegal !== 1'b0) begin
      bad++;
      $display("FAIL illegal_clear: ill=%0b after start, required 0", err_illegal);
    end
    send_load(3, 8'd3, 8'h00);
    wait_end("illegal2");
    total++;
    if ({err_illegal, illegal_addr, done} !== {1'b1, 6'd1, 1'b1}) begin
      bad++;
      $display("FAIL illegal_first: ill=%0b iaddr=%0d done=%0b, required 1 1 1", err_illegal, illegal_addr, done);
    end
  endtask

  task automatic test_bad_csum();
    wr_n = 0;
    words[0] = 32'h00000000;
    pulse_start();
    send_load(1, 8'd1, 8'h01);
    wait_end("csum");
    total++;
    if ({err, cpu_run, done, wr_n == 1} !== 4'b1001) begin
      bad++;
      $display("FAIL csum_err: err=%0b run=%0b done=%0b writes=%0d, required 1 0 0 1", err, cpu_run, done, wr_n);
    end
    pulse_start();
    total++;
    if ({err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL csum_restart: err=%0b busy=%0b, required 0 1", err, busy);
    end
  endtask

  task automatic test_bad_len();
    // loader is in LEN from the previous restart: N=0
    wr_n = 0;
    send_byte(8'd0);
    total++;
    if ({err, busy, byte_ready} !== 3'b100) begin
      bad++;
      $display("FAIL len0: err=%0b busy=%0b rdy=%0b, required 1 0 0", err, busy, byte_ready);
    end
    pulse_start();
    send_byte(8'd65);
    total++;
    if ({err, busy} !== 2'b10) begin
      bad++;
      $display("FAIL len65: err=%0b busy=%0b, required 1 0", err, busy);
    end
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (wr_n !== 0) begin
      bad++;
      $display("FAIL len_nowrite: writes=%0d, required 0", wr_n);
    end
  endtask

  task automatic test_full_gaps();
    int errs = 0;
    wr_n = 0;
    for (int i = 0; i < 64; i++) words[i] = 32'h20080000 | i*32'h00010203;
    gap_max = 2;
    pulse_start();
    send_byte(8'd64);
    send_byte(words[0][31:24]);
    // start while busy must be ignored
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int w = 0; w < 64; w++)
      for (int k = 3; k >= 0; k--)
        if (!(w == 0 && k == 3)) send_byte(words[w][k*8 +: 8]);
    begin
      logic [7:0] cs = 8'h00;
      for (int w = 0; w < 64; w++) cs = cs ^ words[w][31:24] ^ words[w][23:16] ^ words[w][15:8] ^ words[w][7:0];
      send_byte(cs);
    end
    gap_max = 0;
    wait_end("full");
    total++;
    if (wr_n !== 64) begin
      bad++;
      $display("FAIL full_count: writes=%0d, required 64", wr_n);
    end
    for (int i = 0; i < 64 && i < wr_n; i++)
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== words[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL full_data: %0d bad writes, required 0", errs);
    end
    total++;
    if ({done, cpu_run, err, err_illegal, im_addr} !== {4'b1100, 6'd0}) begin
      bad++;
      $display("FAIL full_status: done=%0b run=%0b err=%0b ill=%0b addr=%0d, required 1 1 0 0 0",
               done, cpu_run, err, err_illegal, im_addr);
    end
  endtask

  task automatic test_reset_midload();
    wr_n = 0;
    pulse_start();
    send_byte(8'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    resetn = 1'b0;
    #1;
    total++;
    if ({byte_ready, im_we, im_addr, im_wdata, busy, done, cpu_run, err, err_illegal, illegal_addr} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: rdy=%0b we=%0b addr=%0d wd=%h busy=%0b done=%0b err=%0b, required all 0",
               byte_ready, im_we, im_addr, im_wdata, busy, done, err);
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    words[0] = 32'h3C010001;
    pulse_start();
    send_load(1, 8'd1, 8'h00);
    wait_end("midreset");
    total++;
    if ({done, cpu_run, wr_n == 1, wr_data[0] == 32'h3C010001} !== 4'b1111) begin
      bad++;
      $display("FAIL midreset_reload: done=%0b run=%0b writes=%0d d0=%h, required 1 1 1 3c010001",
               done, cpu_run, wr_n, wr_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_illegal();
    test_bad_csum();
    test_bad_len();
    test_full_gaps();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
